// File: rtl/pipemem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory controller: FSM encoding,
// timeout default and small helpers used by the controller and its counter.
package pipemem_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

    // Counter only has to hold values 0..TIMEOUT-1 before the terminal count fires.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/pipemem_ctrl_if.sv
// Data memory bus between the MEM-stage controller (master) and the memory (slave).
interface pipemem_ctrl_if;

    // Handshake: mem_req rises with mem_we/mem_addr/mem_wdata valid and all four
    // stay stable until the transfer ends; a transfer completes in the cycle where
    // mem_req=1 and mem_ready=1 (mem_rdata valid then); mem_ready is ignored when
    // no request is outstanding.
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/pipemem_tocnt.sv
// BUSY-phase timeout counter: clears while not waiting, counts waiting cycles,
// flags the cycle in which the wait limit is reached.
module pipemem_tocnt
    import pipemem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TIMEOUT-th waiting cycle; TIMEOUT=0 never fires.
    assign tc_o = (TIMEOUT != 0) && en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pipemem_ctrl.sv
// MEM-stage data memory controller: issues one memory access per load/store,
// stalls the pipeline while it is outstanding, and flags misalign/timeout errors.
module pipemem_ctrl
    import pipemem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  mwmem,
    input  logic                  mm2reg,
    input  logic [31:0]           malu,
    input  logic [31:0]           mb,
    pipemem_ctrl_if.master        bus,
    output logic [31:0]           mmo,
    output logic                  stall,
    output logic                  err_misalign,
    output logic                  err_timeout,
    output state_t                dbg_state_o
);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mmo_q, mmo_d;
    logic        mis_q, mis_d;
    logic        to_q, to_d;
    logic        stall_c;

    logic access;
    logic aligned;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    assign access  = mwmem | mm2reg;
    assign aligned = is_aligned(malu[1:0]);
    assign cnt_clr = (state_q != ST_BUSY);
    assign cnt_en  = (state_q == ST_BUSY) && !bus.mem_ready;

    pipemem_tocnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tocnt (
        .clock  (clock),
        .resetn (resetn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d = aligned ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready || cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_c = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mmo_d   = mmo_q;
        mis_d   = mis_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    stall_c = 1'b1;
                    if (aligned) begin
                        req_d   = 1'b1;
                        we_d    = mwmem;
                        addr_d  = malu;
                        wdata_d = mb;
                    end else begin
                        mis_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                // A completion in the same cycle as the limit takes precedence.
                if (bus.mem_ready) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        mmo_d = bus.mem_rdata;
                    end
                end else if (cnt_tc) begin
                    req_d = 1'b0;
                    to_d  = 1'b1;
                    if (!we_q) begin
                        mmo_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mmo_q   <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mmo_q   <= mmo_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

    // Held in reset the pipeline must not see a freeze request.
    assign stall         = stall_c & resetn;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign mmo           = mmo_q;
    assign err_misalign  = mis_q;
    assign err_timeout   = to_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pipemem_ctrl.sv
// Self-checking bench for pipemem_ctrl: directed scenarios plus a randomized
// instruction stream compared every cycle against a transaction-level model.
module tb_pipemem_ctrl;
  import pipemem_ctrl_pkg::*;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        mwmem, mm2reg;
  logic [31:0] malu, mb;
  logic [31:0] mmo;
  logic        stall, err_misalign, err_timeout;
  state_t      dbg_state;

  pipemem_ctrl_if bus();

  pipemem_ctrl #(.TIMEOUT(TO)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .mwmem        (mwmem),
    .mm2reg       (mm2reg),
    .malu         (malu),
    .mb           (mb),
    .bus          (bus),
    .mmo          (mmo),
    .stall        (stall),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy, m_done;
  int          m_age;
  logic        m_req, m_we, m_mis, m_to;
  logic [31:0] m_addr, m_wdata, m_mmo;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 0; m_done <= 0; m_age <= 0;
      m_req <= 0; m_we <= 0; m_addr <= '0; m_wdata <= '0; m_mmo <= '0;
      m_mis <= 0; m_to <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_busy) begin
      if (bus.mem_ready) begin
        m_req <= 0;
        if (!m_we) m_mmo <= bus.mem_rdata;
        m_busy <= 0; m_done <= 1;
      end else if (TO != 0 && m_age + 1 == TO) begin
        m_req <= 0; m_to <= 1;
        if (!m_we) m_mmo <= '0;
        m_busy <= 0; m_done <= 1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (mwmem || mm2reg) begin
      if (malu % 4 != 0) begin
        m_mis <= 1; m_done <= 1;
      end else begin
        m_busy <= 1; m_age <= 0; m_req <= 1;
        m_we <= mwmem; m_addr <= malu; m_wdata <= mb;
      end
    end
  end

  always @(negedge clock) begin
    if (resetn && cmp_en) begin
      chk("stall", 32'(stall), 32'(m_busy || (!m_done && (mwmem || mm2reg))));
      chk("mem_req", 32'(bus.mem_req), 32'(m_req));
      chk("mem_we", 32'(bus.mem_we), 32'(m_we));
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("mmo", mmo, m_mmo);
      chk("err_misalign", 32'(err_misalign), 32'(m_mis));
      chk("err_timeout", 32'(err_timeout), 32'(m_to));
      chk("state", 32'(dbg_state), m_busy ? 32'd1 : (m_done ? 32'd2 : 32'd0));
    end
  end

  // ---------------- scoreboard and bus monitor ----------------
  logic [64:0] exp_q[$];
  logic        prev_req = 1'b0;
  int          req_cycles = 0, stall_cycles = 0, req_pulses = 0, low_run = 0, gap_last = 0;

  always @(negedge clock) begin
    if (resetn && bus.mem_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_req: got addr %h, required no request", bus.mem_addr);
      end else begin
        chk("sb_req_attrs_hi", 32'({bus.mem_we}), 32'(exp_q[0][64]));
        chk("sb_req_addr", bus.mem_addr, exp_q[0][63:32]);
        chk("sb_req_wdata", bus.mem_wdata, exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      if (bus.mem_req) req_cycles <= req_cycles + 1;
      if (stall) stall_cycles <= stall_cycles + 1;
      if (bus.mem_req && !prev_req) begin
        req_pulses <= req_pulses + 1;
        gap_last <= low_run;
      end
      low_run <= bus.mem_req ? 0 : low_run + 1;
    end
    prev_req <= resetn && bus.mem_req;
  end

  // ---------------- memory responder ----------------
  int          fixed_delay = 0;
  bit          spurious = 1'b0;
  bit          use_fix = 1'b0;
  logic [31:0] rdata_fix = '0;

  initial begin
    int wait_n = 0;
    int cur_delay = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (resetn && bus.mem_req) begin
        if (wait_n == 0)
          cur_delay = (fixed_delay >= 0) ? fixed_delay :
                      (($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4));
        bus.mem_ready = (wait_n == cur_delay);
        wait_n++;
      end else begin
        wait_n = 0;
        bus.mem_ready = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      bus.mem_rdata = use_fix ? rdata_fix : $urandom;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_instr(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    mwmem = w; mm2reg = r; malu = a; mb = d;
    if ((w || r) && a[1:0] == 2'b00) exp_q.push_back({w, a, d});
  endtask

  task automatic bubble();
    mwmem = 0; mm2reg = 0;
  endtask

  // Waits until the presented instruction leaves EXE/MEM (stall low at an edge).
  task automatic wait_adv(input int limit, input string name);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (!stall) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: stall still high after %0d cycles, required release", name, limit);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int r0, s0, p0;
    mwmem = 0; mm2reg = 0; malu = '0; mb = '0;
    #12;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mmo", mmo, 32'd0);
    chk("rst_flags", {30'd0, err_misalign, err_timeout}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clock); #1;
    resetn = 1; cmp_en = 1;
    @(posedge clock); #1;

    // load, ready in first BUSY cycle
    use_fix = 1; rdata_fix = 32'hDEADBEEF; fixed_delay = 0;
    r0 = req_cycles; s0 = stall_cycles;
    drive_instr(0, 1, 32'h10, 32'h0);
    wait_adv(10, "load_adv");
    bubble();
    chk("load_req_cycles", 32'(req_cycles - r0), 32'd1);
    chk("load_stall_cycles", 32'(stall_cycles - s0), 32'd2);
    chk("load_mmo", mmo, 32'hDEADBEEF);

    // store, ready after 3 waiting cycles
    fixed_delay = 3;
    r0 = req_cycles; s0 = stall_cycles;
    drive_instr(1, 0, 32'h20, 32'h12345678);
    wait_adv(20, "store_adv");
    bubble();
    chk("store_req_cycles", 32'(req_cycles - r0), 32'd4);
    chk("store_stall_cycles", 32'(stall_cycles - s0), 32'd5);
    chk("store_addr", bus.mem_addr, 32'h20);
    chk("store_wdata", bus.mem_wdata, 32'h12345678);
    chk("store_we", 32'(bus.mem_we), 32'd1);
    chk("store_mmo_kept", mmo, 32'hDEADBEEF);

    // misaligned load
    r0 = req_cycles; s0 = stall_cycles;
    drive_instr(0, 1, 32'h13, 32'h0);
    wait_adv(10, "mis_adv");
    bubble();
    chk("mis_req_cycles", 32'(req_cycles - r0), 32'd0);
    chk("mis_stall_cycles", 32'(stall_cycles - s0), 32'd1);
    chk("mis_flag", 32'(err_misalign), 32'd1);
    chk("mis_mmo_kept", mmo, 32'hDEADBEEF);

    // timeout on a load
    fixed_delay = 1000;
    r0 = req_cycles; s0 = stall_cycles;
    drive_instr(0, 1, 32'h40, 32'h0);
    wait_adv(40, "to_adv");
    bubble();
    chk("to_req_cycles", 32'(req_cycles - r0), 32'd15);
    chk("to_stall_cycles", 32'(stall_cycles - s0), 32'd16);
    chk("to_flag", 32'(err_timeout), 32'd1);
    chk("to_mmo", mmo, 32'd0);

    // back-to-back load then store
    fixed_delay = 0;
    p0 = req_pulses;
    drive_instr(0, 1, 32'h44, 32'h0);
    wait_adv(10, "b2b_load_adv");
    drive_instr(1, 0, 32'h48, 32'hCAFEF00D);
    wait_adv(10, "b2b_store_adv");
    bubble();
    chk("b2b_pulses", 32'(req_pulses - p0), 32'd2);
    chk("b2b_gap", 32'(gap_last), 32'd2);

    // asynchronous reset while a load is pending
    fixed_delay = 1000;
    drive_instr(0, 1, 32'h50, 32'h0);
    @(posedge clock); #1;
    chk("rstb_req_before", 32'(bus.mem_req), 32'd1);
    @(negedge clock); #2;
    resetn = 0;
    #1;
    chk("rstb_req", 32'(bus.mem_req), 32'd0);
    chk("rstb_we_addr", bus.mem_addr | 32'(bus.mem_we), 32'd0);
    chk("rstb_wdata", bus.mem_wdata, 32'd0);
    chk("rstb_mmo", mmo, 32'd0);
    chk("rstb_flags", {30'd0, err_misalign, err_timeout}, 32'd0);
    chk("rstb_stall", 32'(stall), 32'd0);
    chk("rstb_state", 32'(dbg_state), 32'd0);
    bubble();
    @(posedge clock); #1;
    resetn = 1;
    @(posedge clock); #1;

    // randomized instruction stream with random latency and spurious ready
    fixed_delay = -1; spurious = 1; use_fix = 0;
    for (int n = 0; n < 250; n++) begin
      int k;
      logic [31:0] a, d;
      k = $urandom_range(0, 9);
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      if (k <= 1) bubble();
      else if (k <= 4) drive_instr(0, 1, a, d);
      else if (k <= 7) drive_instr(1, 0, a, d);
      else if (k == 8) drive_instr(1, 1, a, d);
      else drive_instr(0, 1, a | 32'($urandom_range(1, 3)), d);
      wait_adv(40, "rand_adv");
    end
    bubble();
    repeat (3) @(posedge clock);
    #1;
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipemem_ctrl.md
PIPEMEM_CTRL -- requirements
Module: pipemem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: max BUSY cycles awaiting mem_ready; 0 disables timeout.
REQ-002 clock  input  1  pipeline clock; all state changes on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 mwmem  input  1  MEM-stage store request, from EXE/MEM register.
REQ-005 mm2reg  input  1  MEM-stage load request, from EXE/MEM register.
REQ-006 malu  input  32  MEM-stage effective address.
REQ-007 mb  input  32  MEM-stage store data.
REQ-008 mem_ready  input  1  data memory completion strobe, sampled only in BUSY.
REQ-009 mem_rdata  input  32  data memory read data, valid when mem_ready=1.
REQ-010 mem_req  output  1  registered access request to data memory.
REQ-011 mem_we  output  1  registered write enable; 1=store, 0=load.
REQ-012 mem_addr  output  32  registered address.
REQ-013 mem_wdata  output  32  registered store data.
REQ-014 mmo  output  32  registered load result presented to MEM/WB register.
REQ-015 stall  output  1  combinational freeze of PC, IF/ID, ID/EXE and EXE/MEM registers.
REQ-016 err_misalign  output  1  sticky misaligned-access flag.
REQ-017 err_timeout  output  1  sticky memory-timeout flag.

Function
REQ-018 FSM SHALL have states IDLE, BUSY, DONE.
REQ-019 Access = mwmem|mm2reg; stall SHALL be 1 in IDLE with access, 1 in BUSY, and 0 otherwise.
REQ-020 IDLE, access, malu[1:0]==0: next state BUSY; mem_req<=1, mem_addr<=malu, mem_wdata<=mb, mem_we<=mwmem.
REQ-021 IDLE, access, malu[1:0]!=0: no request; err_misalign<=1; next state DONE; mmo unchanged.
REQ-022 IDLE, no access: remain IDLE; all outputs hold.
REQ-023 BUSY: mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable until exit.
REQ-024 BUSY with mem_ready=1: mem_req<=0; if mem_we=0 then mmo<=mem_rdata; next state DONE.
REQ-025 BUSY timeout counter SHALL clear on BUSY entry and increment each BUSY cycle with mem_ready=0.
REQ-026 Counter reaching TIMEOUT (TIMEOUT!=0) SHALL abort: mem_req<=0, err_timeout<=1, mmo<=0 on loads, next state DONE.
REQ-027 mem_ready and timeout in the same cycle: mem_ready SHALL win.
REQ-028 DONE SHALL last exactly one cycle with stall=0 so the instruction advances, then go to IDLE unconditionally.
REQ-029 Access inputs SHALL be ignored in DONE; each instruction is issued at most once.
REQ-030 mwmem=mm2reg=1: treated as store; mmo unchanged.
REQ-031 Minimum latency: access entering IDLE at cycle 0 gives mem_req=1 at cycle 1; mem_ready at cycle 1 gives DONE at cycle 2, so 2 stall cycles.
REQ-032 Back-to-back accesses: the second is issued from IDLE in the cycle after DONE.
REQ-033 mem_ready outside BUSY SHALL be ignored.
REQ-034 Error flags SHALL be sticky and cleared only by reset.

Reset
REQ-035 resetn=0 SHALL immediately force state IDLE and clear mem_req, mem_we, mem_addr, mem_wdata, mmo, err_misalign, err_timeout and the counter to 0.
REQ-036 Reset during BUSY SHALL drop mem_req asynchronously; the aborted access is not retried.

Structure
REQ-037 Shared pipeline package SHALL hold the FSM state encoding (IDLE=0, BUSY=1, DONE=2, 2 bits) and the TIMEOUT default.
REQ-038 The timeout counter SHALL be one sub-module, pipemem_tocnt, with clear, enable and terminal-count output.

Verification
REQ-039 Load: mm2reg=1, malu=0x00000010, mem_ready at first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_req high 1 cycle, mmo=0xDEADBEEF, stall high 2 cycles.
REQ-040 Store: mwmem=1, malu=0x20, mb=0x12345678, mem_ready after 3 cycles -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 stable for 4 cycles, mmo unchanged.
REQ-041 Misaligned: mm2reg=1, malu=0x00000013 -> no mem_req, err_misalign=1, stall for 1 cycle, DONE follows.
REQ-042 Timeout: load with mem_ready tied 0, TIMEOUT=15 -> mem_req drops after 15 BUSY cycles, err_timeout=1, mmo=0.
REQ-043 Reset mid-BUSY: resetn=0 during a pending load -> mem_req=0 and state IDLE without a clock edge, all outputs 0.
REQ-044 Back-to-back: a load then a store on consecutive instructions -> exactly two mem_req pulses, separated by one DONE cycle and one IDLE cycle.
